// File: rtl/input_debouncer_pkg.sv
// Shared constants and helpers for the switch/button debouncer slice.
// Board defaults: 10 ms acceptance window at 100 MHz, two-flop synchroniser.
package input_debouncer_pkg;

  localparam int DEB_CNT_MAX_100MHZ_10MS = 1000000;
  localparam int DEB_SYNC_STAGES         = 2;
  localparam int DEB_WIDTH               = 16;

  // Per-bit FSM encoding.
  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_SETTLING = 1'b1;

  // Counter width; a one-bit floor keeps degenerate parameters legal.
  function automatic int deb_cnt_width(input int cnt_max);
    int w;
    w = $clog2(cnt_max);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/input_debouncer_debounce_bit.sv
// Single-bit conditioner: synchroniser chain, 2-state stability FSM and counter.
// ACCEPT is the combinational next-cycle strobe, so the parent can register CHANGED in step with RISE/FALL.
module debounce_bit
  import input_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES = DEB_SYNC_STAGES,
  parameter int CNT_MAX     = DEB_CNT_MAX_100MHZ_10MS
) (
  input  logic CLK,
  input  logic RST,
  input  logic I,
  output logic O,
  output logic RISE,
  output logic FALL,
  output logic ACCEPT
);

  localparam int                CW       = deb_cnt_width(CNT_MAX);
  localparam logic [CW-1:0]     CNT_LAST = CW'(CNT_MAX - 1);
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [0:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   o_q, o_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], I};
  assign s      = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    o_d     = o_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s != o_q) begin
          state_d = ST_SETTLING;
          cnt_d   = CNT_ONE;
        end
      end
      ST_SETTLING: begin
        if (s == o_q) begin
          // Bounce back to the accepted level: all progress is dropped.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          o_d     = s;
          rise_d  = s;
          fall_d  = ~s;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q  <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      o_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign O      = o_q;
  assign RISE   = rise_q;
  assign FALL   = fall_q;
  assign ACCEPT = rise_d | fall_d;

endmodule

// File: rtl/input_debouncer.sv
// WIDTH independent debounce_bit lanes plus a shared CHANGED register.
// Every output is a flop; IN_RAW only reaches logic through the synchronisers.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int WIDTH       = DEB_WIDTH,
  parameter int SYNC_STAGES = DEB_SYNC_STAGES,
  parameter int CNT_MAX     = DEB_CNT_MAX_100MHZ_10MS
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] IN_RAW,
  output logic [WIDTH-1:0] O,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL,
  output logic             CHANGED
);

  logic [WIDTH-1:0] accept;
  logic             changed_q, changed_d;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_MAX     (CNT_MAX)
    ) u_bit (
      .CLK    (CLK),
      .RST    (RST),
      .I      (IN_RAW[g]),
      .O      (O[g]),
      .RISE   (RISE[g]),
      .FALL   (FALL[g]),
      .ACCEPT (accept[g])
    );
  end

  // Simultaneous acceptances on several lanes collapse into one CHANGED cycle.
  assign changed_d = |accept;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) changed_q <= 1'b0;
    else     changed_q <= changed_d;
  end

  assign CHANGED = changed_q;

endmodule
